// File: rtl/handshake_pkg.sv
// rtl/handshake_pkg.sv - shared types and helpers for the handshake FIFO packer
//
// Purpose: packer state enum and the lane-count width helper.
// Ports: none (package).

package handshake_pkg;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } packerState_t;

  // Width needed to hold a lane count of 0..ratio inclusive.
  function automatic int countWidth(input int ratio);
    return $clog2(ratio + 1);
  endfunction

endpackage

// File: rtl/handshake_fifo_packer.sv
// rtl/handshake_fifo_packer.sv - packs RATIO FIFO words into one wide REQ/ACK word
//
// Purpose: drains WIDTH-bit words from a REQ/ACK FIFO port and assembles
// RATIO of them into one wide word, with Flush for partial words.
// Ports:
//   clk, async_rst_n, clk_en   clock, async active-low reset, clock enable
//   FifoREQ/FifoACK/FifoData   narrow input handshake from the FIFO
//   Flush                      emit the current partial word
//   PackedREQ/PackedACK        wide output handshake
//   PackedData                 lane i at [i*WIDTH +: WIDTH]
//   PackedCount                number of valid lanes in PackedData

module handshake_fifo_packer
  import handshake_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int RATIO     = 4,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                           clk,
  input  logic                           async_rst_n,
  input  logic                           clk_en,
  input  logic                           FifoREQ,
  output logic                           FifoACK,
  input  logic [WIDTH-1:0]               FifoData,
  input  logic                           Flush,
  output logic                           PackedREQ,
  input  logic                           PackedACK,
  output logic [WIDTH*RATIO-1:0]         PackedData,
  output logic [countWidth(RATIO)-1:0]   PackedCount
);

  localparam int CW         = countWidth(RATIO);
  localparam int FIRST_LANE = MSB_FIRST ? RATIO - 1 : 0;

  packerState_t            state;
  packerState_t            nextState;
  logic [CW-1:0]           cnt;
  logic [CW-1:0]           cntNext;
  logic [CW-1:0]           countQ;
  logic [CW-1:0]           countNext;
  logic [WIDTH*RATIO-1:0]  lanes;
  logic [WIDTH*RATIO-1:0]  lanesNext;
  logic                    readyQ;
  logic [CW-1:0]           laneIdx;
  logic                    lastLane;
  logic                    inXfer;
  logic                    outXfer;
  logic                    flushOnly;

  assign laneIdx   = MSB_FIRST ? (CW'(RATIO - 1) - cnt) : cnt;
  assign lastLane  = (cnt == CW'(RATIO - 1));
  assign inXfer    = clk_en & FifoREQ & FifoACK;
  assign outXfer   = clk_en & PackedREQ & PackedACK;
  // Flush without a word in the same cycle; ignored on an empty packer.
  assign flushOnly = clk_en & Flush & ~inXfer & (cnt != '0);

  // State register
  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      state <= FILL;
    end else begin
      state <= nextState;
    end
  end

  // Next-state logic
  always_comb begin
    nextState = state;
    case (state)
      FILL: begin
        if ((inXfer && (lastLane || Flush)) || flushOnly) begin
          nextState = HOLD;
        end
      end
      HOLD: begin
        if (outXfer) begin
          nextState = FILL;
        end
      end
      default: nextState = FILL;
    endcase
  end

  // Output logic. readyQ keeps FifoACK low until the first enabled edge
  // after reset, so nothing is accepted while reset is asserted.
  always_comb begin
    PackedREQ = (state == HOLD);
    FifoACK   = readyQ & clk_en & ((state == FILL) | PackedACK);
  end

  // Lane, count and valid-lane datapath
  always_comb begin
    lanesNext = lanes;
    cntNext   = cnt;
    countNext = countQ;
    if (state == FILL) begin
      if (inXfer) begin
        for (int i = 0; i < RATIO; i++) begin
          if (laneIdx == CW'(i)) begin
            lanesNext[i*WIDTH +: WIDTH] = FifoData;
          end
        end
        if (lastLane || Flush) begin
          countNext = cnt + CW'(1);
        end else begin
          cntNext = cnt + CW'(1);
        end
      end else if (flushOnly) begin
        countNext = cnt;
      end
    end else if (outXfer) begin
      // A word accepted in the same cycle starts the next packed word.
      lanesNext = '0;
      countNext = '0;
      cntNext   = '0;
      if (inXfer) begin
        lanesNext[FIRST_LANE*WIDTH +: WIDTH] = FifoData;
        cntNext = CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      lanes  <= '0;
      cnt    <= '0;
      countQ <= '0;
      readyQ <= 1'b0;
    end else begin
      lanes  <= lanesNext;
      cnt    <= cntNext;
      countQ <= countNext;
      if (clk_en) begin
        readyQ <= 1'b1;
      end
    end
  end

  assign PackedData  = lanes;
  assign PackedCount = countQ;

endmodule

// File: tb/tb_handshake_fifo_packer.sv
// tb/tb_handshake_fifo_packer.sv - directed bench for handshake_fifo_packer

module tb_handshake_fifo_packer;

  logic        clk = 1'b0;
  logic        async_rst_n;
  logic        clk_en;
  logic        FifoREQ;
  logic [7:0]  FifoData;
  logic        Flush;
  logic        PackedACK;

  logic        FifoACK, FifoACK2;
  logic        PackedREQ, PackedREQ2;
  logic [31:0] PackedData, PackedData2;
  logic [2:0]  PackedCount, PackedCount2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  handshake_fifo_packer #(.WIDTH(8), .RATIO(4), .MSB_FIRST(1'b0)) dut (
    .clk(clk), .async_rst_n(async_rst_n), .clk_en(clk_en),
    .FifoREQ(FifoREQ), .FifoACK(FifoACK), .FifoData(FifoData),
    .Flush(Flush), .PackedREQ(PackedREQ), .PackedACK(PackedACK),
    .PackedData(PackedData), .PackedCount(PackedCount)
  );

  handshake_fifo_packer #(.WIDTH(8), .RATIO(4), .MSB_FIRST(1'b1)) dutMsb (
    .clk(clk), .async_rst_n(async_rst_n), .clk_en(clk_en),
    .FifoREQ(FifoREQ), .FifoACK(FifoACK2), .FifoData(FifoData),
    .Flush(Flush), .PackedREQ(PackedREQ2), .PackedACK(PackedACK),
    .PackedData(PackedData2), .PackedCount(PackedCount2)
  );

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one word, check FifoACK before the edge, then clock it in.
  task automatic sendWord(input logic [7:0] d, input logic expAck, input string tag);
    FifoREQ  = 1'b1;
    FifoData = d;
    #1;
    check(tag, {63'd0, FifoACK}, {63'd0, expAck});
    tick();
    FifoREQ = 1'b0;
  endtask

  initial begin
    async_rst_n = 1'b0;
    clk_en      = 1'b1;
    FifoREQ     = 1'b1;
    FifoData    = 8'h00;
    Flush       = 1'b0;
    PackedACK   = 1'b1;

    // Reset
    #12;
    check("rst_fifoack", {63'd0, FifoACK}, 64'd0);
    check("rst_preq", {63'd0, PackedREQ}, 64'd0);
    check("rst_pdata", {32'd0, PackedData}, 64'd0);
    check("rst_pcount", {61'd0, PackedCount}, 64'd0);
    async_rst_n = 1'b1;
    #1;
    check("rel_fifoack_pre", {63'd0, FifoACK}, 64'd0);
    tick();
    check("rel_fifoack", {63'd0, FifoACK}, 64'd1);
    check("rel_preq", {63'd0, PackedREQ}, 64'd0);
    FifoREQ = 1'b0;

    // Stream, back-to-back
    sendWord(8'h11, 1'b1, "st_ack0");
    sendWord(8'h22, 1'b1, "st_ack1");
    sendWord(8'h33, 1'b1, "st_ack2");
    check("st_preq_early", {63'd0, PackedREQ}, 64'd0);
    sendWord(8'h44, 1'b1, "st_ack3");
    check("st_preq", {63'd0, PackedREQ}, 64'd1);
    check("st_data", {32'd0, PackedData}, 64'h44332211);
    check("st_count", {61'd0, PackedCount}, 64'd4);
    check("msb_preq", {63'd0, PackedREQ2}, 64'd1);
    check("msb_data", {32'd0, PackedData2}, 64'h11223344);
    check("msb_count", {61'd0, PackedCount2}, 64'd4);
    sendWord(8'h55, 1'b1, "st_ack4");
    check("st_preq_b2b", {63'd0, PackedREQ}, 64'd0);
    check("st_data_b2b", {32'd0, PackedData}, 64'h00000055);
    check("msb_data_b2b", {32'd0, PackedData2}, 64'h55000000);
    sendWord(8'h66, 1'b1, "st_ack5");
    sendWord(8'h77, 1'b1, "st_ack6");
    sendWord(8'h88, 1'b1, "st_ack7");
    check("st2_data", {32'd0, PackedData}, 64'h88776655);
    check("st2_count", {61'd0, PackedCount}, 64'd4);
    tick();
    check("st_drain_preq", {63'd0, PackedREQ}, 64'd0);
    check("st_drain_data", {32'd0, PackedData}, 64'd0);
    check("st_drain_count", {61'd0, PackedCount}, 64'd0);

    // Back-pressure
    PackedACK = 1'b0;
    sendWord(8'h01, 1'b1, "bp_ack0");
    sendWord(8'h02, 1'b1, "bp_ack1");
    sendWord(8'h03, 1'b1, "bp_ack2");
    sendWord(8'h04, 1'b1, "bp_ack3");
    FifoREQ  = 1'b1;
    FifoData = 8'hEE;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_fifoack", {63'd0, FifoACK}, 64'd0);
      check("bp_preq", {63'd0, PackedREQ}, 64'd1);
      check("bp_data", {32'd0, PackedData}, 64'h04030201);
      tick();
    end
    PackedACK = 1'b1;
    sendWord(8'h99, 1'b1, "bp_resume_ack");
    check("bp_resume_preq", {63'd0, PackedREQ}, 64'd0);
    check("bp_resume_data", {32'd0, PackedData}, 64'h00000099);
    sendWord(8'hA2, 1'b1, "bp_a2");
    sendWord(8'hA3, 1'b1, "bp_a3");
    sendWord(8'hA4, 1'b1, "bp_a4");
    check("bp_next_data", {32'd0, PackedData}, 64'hA4A3A299);
    check("bp_next_count", {61'd0, PackedCount}, 64'd4);
    tick();

    // Flush of a partial word
    sendWord(8'hAA, 1'b1, "fl_ack0");
    sendWord(8'hBB, 1'b1, "fl_ack1");
    PackedACK = 1'b0;
    Flush = 1'b1;
    tick();
    Flush = 1'b0;
    check("fl_preq", {63'd0, PackedREQ}, 64'd1);
    check("fl_data", {32'd0, PackedData}, 64'h0000BBAA);
    check("fl_count", {61'd0, PackedCount}, 64'd2);
    Flush = 1'b1;
    tick();
    Flush = 1'b0;
    check("fl_hold_count", {61'd0, PackedCount}, 64'd2);
    PackedACK = 1'b1;
    tick();
    check("fl_drain_preq", {63'd0, PackedREQ}, 64'd0);

    // Flush together with an input word
    sendWord(8'hDD, 1'b1, "flc_ack0");
    PackedACK = 1'b0;
    Flush = 1'b1;
    sendWord(8'hCC, 1'b1, "flc_ack1");
    Flush = 1'b0;
    check("flc_preq", {63'd0, PackedREQ}, 64'd1);
    check("flc_data", {32'd0, PackedData}, 64'h0000CCDD);
    check("flc_count", {61'd0, PackedCount}, 64'd2);
    PackedACK = 1'b1;
    tick();

    // Flush on an empty packer
    Flush = 1'b1;
    tick();
    Flush = 1'b0;
    check("fle_preq", {63'd0, PackedREQ}, 64'd0);
    check("fle_count", {61'd0, PackedCount}, 64'd0);

    // clk_en gating mid-word
    sendWord(8'h10, 1'b1, "ce_ack0");
    sendWord(8'h20, 1'b1, "ce_ack1");
    clk_en   = 1'b0;
    FifoREQ  = 1'b1;
    FifoData = 8'h77;
    Flush    = 1'b1;
    #1;
    check("ce_fifoack", {63'd0, FifoACK}, 64'd0);
    tick();
    tick();
    tick();
    check("ce_data_hold", {32'd0, PackedData}, 64'h00002010);
    check("ce_preq_hold", {63'd0, PackedREQ}, 64'd0);
    clk_en  = 1'b1;
    Flush   = 1'b0;
    FifoREQ = 1'b0;
    sendWord(8'h30, 1'b1, "ce_ack2");
    sendWord(8'h40, 1'b1, "ce_ack3");
    PackedACK = 1'b0;
    check("ce_data", {32'd0, PackedData}, 64'h40302010);
    check("ce_count", {61'd0, PackedCount}, 64'd4);
    check("ce_preq", {63'd0, PackedREQ}, 64'd1);

    // Asynchronous reset between edges while holding
    #2;
    async_rst_n = 1'b0;
    #1;
    check("ar_preq", {63'd0, PackedREQ}, 64'd0);
    check("ar_preq_msb", {63'd0, PackedREQ2}, 64'd0);
    check("ar_data", {32'd0, PackedData}, 64'd0);
    check("ar_count", {61'd0, PackedCount}, 64'd0);
    check("ar_fifoack", {63'd0, FifoACK}, 64'd0);
    tick();
    async_rst_n = 1'b1;
    tick();
    check("ar_rel_fifoack", {63'd0, FifoACK}, 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/handshake_fifo_packer.md
# handshake_fifo_packer

Read-side consumer for the REQ/ACK handshake FIFO. It drains WIDTH-bit words from the FIFO output port and packs RATIO consecutive words into one wide word. The wide word is presented on a second REQ/ACK port toward wide datapaths such as memory write bursts and bus bridges. A Flush input emits a partially filled word with its valid-lane count, and back-to-back operation sustains full input throughput.

## Interface
- WIDTH, 32, bits per FIFO word
- RATIO, 4, words per packed output; must be at least 2
- MSB_FIRST, 0, 0 = first word received goes to lane 0 (LSBs); 1 = first word goes to lane RATIO-1
- clk  input  1  single clock; all state updates on rising edge
- async_rst_n  input  1  asynchronous, active-low reset
- clk_en  input  1  global clock enable; no transfer or state change while low
- FifoREQ  input  1  FIFO output word valid
- FifoACK  output  1  packer accepts FifoData this cycle
- FifoData  input  WIDTH  word from the FIFO
- Flush  input  1  emit the current partial word
- PackedREQ  output  1  packed word valid
- PackedACK  input  1  downstream accepts the packed word
- PackedData  output  WIDTH*RATIO  packed word; lane i occupies [i*WIDTH +: WIDTH]
- PackedCount  output  $clog2(RATIO+1)  number of valid lanes, 1..RATIO

## Operation
- **Transfer rule:**
  - An input transfer occurs when clk_en & FifoREQ & FifoACK are all high.
  - An output transfer occurs when clk_en & PackedREQ & PackedACK are all high.
- **States:**
  - FILL: PackedREQ=0, FifoACK=clk_en.
  - HOLD: PackedREQ=1, FifoACK=clk_en & PackedACK.
- **Lane count:** a fill counter `cnt` (0..RATIO-1) selects the lane for the next word. The lane index is `cnt`, or RATIO-1-`cnt` when MSB_FIRST=1.
- **FILL, input transfer, `cnt` < RATIO-1:** the word is written to its lane and `cnt` increments.
- **FILL, input transfer, `cnt` = RATIO-1:** the word is written, PackedCount=RATIO, and the state goes to HOLD.
- **FILL, Flush with `cnt` > 0 and no input transfer:** PackedCount=`cnt` and the state goes to HOLD. Unfilled lanes read 0.
- **FILL, Flush together with an input transfer:** the word is written first, then PackedCount=`cnt`+1 and the state goes to HOLD. If `cnt`+1 = RATIO, this is the same as a normal fill.
- **FILL, Flush with `cnt`=0 and no input transfer:** ignored.
- **HOLD, output transfer without an input transfer:** all lanes clear to 0, `cnt`=0, and the state goes to FILL.
- **HOLD, output transfer with an input transfer in the same cycle:** all lanes clear, the new word goes to the first lane, `cnt`=1, and the state goes to FILL. If RATIO words arrive back-to-back, no input bubble occurs.
- **HOLD, other cases:** Flush is ignored, and PackedData and PackedCount stay stable until accepted.
- **Signal dependencies:**
  - PackedREQ, PackedData and PackedCount are registered and never depend combinationally on any input.
  - FifoACK depends combinationally only on state, clk_en and PackedACK.

## Timing
- **Reset values (async_rst_n low):**
  - State FILL, `cnt`=0, lanes 0.
  - PackedREQ=0, PackedData=0, PackedCount=0.
  - FifoACK=0 while reset is asserted; after release it follows the FILL rule.
- **Reset mid-operation:** asserting async_rst_n in HOLD drops PackedREQ immediately, without waiting for a clock edge, and discards the partial or held word.
- **Latency:** PackedREQ rises on the edge that accepts the last word or the Flush, so it is visible one cycle after that transfer.
- **Throughput:**
  - Input: one word per cycle, sustained, when PackedACK is high.
  - Output: one packed word every RATIO cycles.
- **Back-pressure:** PackedACK low in HOLD forces FifoACK low. The FIFO is not drained while the output is stalled.
- **clk_en low:** all registers hold, FifoACK=0, and a transfer that would otherwise occur is not counted.
- **Width rule:** PackedCount is zero-extended. `cnt` never exceeds RATIO-1 and has no wrap except the reset to 0/1 on an output transfer.

## Structure
- **Shared package `handshake_pkg`:**
  - Packer state enum typedef (FILL, HOLD).
  - Count-width function clog2(RATIO+1).
- **Sub-modules:** none needed. The lane write decoder, counter and state register are inline.
- **Integration:** the FIFO itself is instantiated by the parent and connects its output port directly to the Fifo* ports.

## Test plan
All scenarios use WIDTH=8, RATIO=4, MSB_FIRST=0 unless stated.
- **Reset:** hold async_rst_n low with FifoREQ=1 -> FifoACK=0, PackedREQ=0, PackedData=0x00000000, PackedCount=0. Release, and FifoACK=1 on the next cycle with clk_en=1.
- **Stream:** with PackedACK=1, send 0x11, 0x22, 0x33, 0x44 back-to-back -> PackedData=0x44332211 and PackedCount=4 one cycle after 0x44. Continue with 0x55, 0x66, 0x77, 0x88, and FifoACK stays high for all 8 cycles.
- **Back-pressure:** fill four words with PackedACK=0 for 5 cycles -> FifoACK=0 and PackedData stable. Then assert PackedACK together with FifoREQ carrying 0x99 -> the next word starts with lane0=0x99 and `cnt`=1.
- **Flush:** send 0xAA, 0xBB, then Flush for one cycle -> 0x0000BBAA with PackedCount=2.
  - Flush with 0xCC concurrent after 0xDD -> 0x0000CCDD with PackedCount=2.
  - Flush with an empty packer -> no PackedREQ.
- **clk_en gating:** drop clk_en mid-word -> no lane or count change and FifoACK=0. Resume, and the packed word matches an ungated run.
- **MSB_FIRST and async reset:** with MSB_FIRST=1, send 0x11, 0x22, 0x33, 0x44 -> 0x11223344. Then assert async_rst_n low between edges in HOLD -> PackedREQ falls before the next edge.
